// File: rtl/compound_adder_pipe_if.sv
// rtl/compound_adder_pipe_if.sv - operand/result handshake bundle for compound_adder_pipe
interface compound_adder_pipe_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic [WIDTH-1:0] sum_p1;
    logic             cout_p1;
    logic             ovf_p1;

    // Producer/consumer side: drives operands and result acceptance
    modport master (
        output in_valid, a, b, cin, op, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, sum_p1, cout_p1, ovf_p1
    );

    // Adder side
    modport slave (
        input  in_valid, a, b, cin, op, out_ready,
        output in_ready, out_valid, sum, cout, ovf, sum_p1, cout_p1, ovf_p1
    );
endinterface

// File: rtl/compound_adder_pipe.sv
// rtl/compound_adder_pipe.sv - pipelined compound adder returning a+b'+cin and a+b'+cin+1
module compound_adder_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    compound_adder_pipe_if.slave bus
);
    // Slice width; the top slice absorbs any remainder so it always holds the sign bit.
    localparam int SW = WIDTH / STAGES;

    logic adv;

    // The whole pipe moves whenever the output register is empty or being drained.
    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SW;
        localparam int HI = (k == STAGES - 1) ? WIDTH - 1 : LO + SW - 1;
        localparam int SL = HI - LO + 1;

        logic             vld_in;
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] s_in;
        logic [WIDTH-1:0] p_in;
        logic             c_in;
        logic [1:0]       e_in;
        logic [SL+1:0]    x0;
        logic [SL+1:0]    x1;
        logic [SL+1:0]    x2;
        logic [SL+1:0]    rs;
        logic [SL+1:0]    rp;
        logic [WIDTH-1:0] s_d;
        logic [WIDTH-1:0] p_d;
        logic             unused_stage;

        if (k == 0) begin : g_head
            // Operand conditioning: subtract inverts b, cin seeds the sum chain and
            // cin+1 seeds the sum_p1 chain (which can therefore carry 2).
            assign vld_in = bus.in_valid;
            assign a_in   = bus.a;
            assign b_in   = bus.op ? ~bus.b : bus.b;
            assign s_in   = '0;
            assign p_in   = '0;
            assign c_in   = bus.cin;
            assign e_in   = bus.cin ? 2'd2 : 2'd1;
        end else begin : g_link
            assign vld_in = g_stage[k-1].g_mid.vld_q;
            assign a_in   = g_stage[k-1].g_mid.a_q;
            assign b_in   = g_stage[k-1].g_mid.b_q;
            assign s_in   = g_stage[k-1].g_mid.s_q;
            assign p_in   = g_stage[k-1].g_mid.p_q;
            assign c_in   = g_stage[k-1].g_mid.c_q;
            assign e_in   = g_stage[k-1].g_mid.e_q;
        end

        // Compound set for this slice: x, x+1 and x+2 (the last only when both +1s land).
        assign x0 = {2'b00, a_in[HI:LO]} + {2'b00, b_in[HI:LO]};
        assign x1 = x0 + (SL+2)'(1);
        assign x2 = x0 + (SL+2)'(2);
        assign rs = c_in ? x1 : x0;

        // Pick the sum_p1 slice from the compound set by its incoming carry (0, 1 or 2).
        always_comb begin
            case (e_in)
                2'd0:    rp = x0;
                2'd1:    rp = x1;
                default: rp = x2;
            endcase
        end

        // Merge this slice's resolved bits into the partial results carried down the pipe.
        always_comb begin
            s_d         = s_in;
            s_d[HI:LO]  = rs[SL-1:0];
            p_d         = p_in;
            p_d[HI:LO]  = rp[SL-1:0];
        end

        // Bits not needed at this point: unresolved partial-result slices, consumed
        // operand slices, and the carry bit that cannot be set on the sum chain.
        assign unused_stage = ^{s_in, p_in, a_in, b_in, rs[SL+1], rp[SL+1]};

        if (k < STAGES - 1) begin : g_mid
            logic             vld_q;
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;
            logic [WIDTH-1:0] s_q;
            logic [WIDTH-1:0] p_q;
            logic             c_q;
            logic [1:0]       e_q;

            // Intermediate stage: shift forward on advance, empty on reset.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    vld_q <= 1'b0;
                    a_q   <= '0;
                    b_q   <= '0;
                    s_q   <= '0;
                    p_q   <= '0;
                    c_q   <= 1'b0;
                    e_q   <= 2'd0;
                end else if (adv) begin
                    vld_q <= vld_in;
                    a_q   <= a_in;
                    b_q   <= b_in;
                    s_q   <= s_d;
                    p_q   <= p_d;
                    c_q   <= rs[SL];
                    e_q   <= rp[SL+1:SL];
                end
            end
        end else begin : g_tail
            logic             vld_q;
            logic [WIDTH-1:0] sum_q;
            logic [WIDTH-1:0] sum_p1_q;
            logic             cout_q;
            logic             cout_p1_q;
            logic             ovf_q;
            logic             ovf_p1_q;

            // Output register: final carries are bit WIDTH of each chain; overflow uses
            // the operand sign bits, which live in this top slice.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    vld_q     <= 1'b0;
                    sum_q     <= '0;
                    sum_p1_q  <= '0;
                    cout_q    <= 1'b0;
                    cout_p1_q <= 1'b0;
                    ovf_q     <= 1'b0;
                    ovf_p1_q  <= 1'b0;
                end else if (adv) begin
                    vld_q     <= vld_in;
                    sum_q     <= s_d;
                    sum_p1_q  <= p_d;
                    cout_q    <= rs[SL];
                    cout_p1_q <= rp[SL];
                    ovf_q     <= (a_in[WIDTH-1] == b_in[WIDTH-1]) && (s_d[WIDTH-1] != a_in[WIDTH-1]);
                    ovf_p1_q  <= (a_in[WIDTH-1] == b_in[WIDTH-1]) && (p_d[WIDTH-1] != a_in[WIDTH-1]);
                end
            end

            assign bus.out_valid = vld_q;
            assign bus.sum       = sum_q;
            assign bus.sum_p1    = sum_p1_q;
            assign bus.cout      = cout_q;
            assign bus.cout_p1   = cout_p1_q;
            assign bus.ovf       = ovf_q;
            assign bus.ovf_p1    = ovf_p1_q;
        end
    end
endmodule

// File: tb/tb_compound_adder_pipe.sv
// tb/tb_compound_adder_pipe.sv - self-checking bench for compound_adder_pipe (WIDTH=16, STAGES=2)
module tb_compound_adder_pipe;
    localparam int W = 16;
    localparam int S = 2;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        op;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic [15:0] sum_p1;
        logic        cout_p1;
        logic        ovf_p1;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_run  = 0;
    int   n_fail = 0;

    compound_adder_pipe_if #(.WIDTH(W)) bus ();

    compound_adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic rec_t mk(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                input logic op, input logic [15:0] sum, input logic cout,
                                input logic ovf, input logic [15:0] sum_p1, input logic cout_p1,
                                input logic ovf_p1);
        rec_t r;
        r.a = a; r.b = b; r.cin = cin; r.op = op;
        r.sum = sum; r.cout = cout; r.ovf = ovf;
        r.sum_p1 = sum_p1; r.cout_p1 = cout_p1; r.ovf_p1 = ovf_p1;
        return r;
    endfunction

    // Reference: plain 17-bit arithmetic, no slicing.
    function automatic rec_t model(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                   input logic op);
        rec_t        r;
        logic [15:0] bp;
        logic [16:0] t;
        logic [16:0] t1;
        bp = op ? ~b : b;
        t  = {1'b0, a} + {1'b0, bp} + {16'd0, cin};
        t1 = t + 17'd1;
        r.a = a; r.b = b; r.cin = cin; r.op = op;
        r.sum     = t[15:0];
        r.cout    = t[16];
        r.ovf     = (a[15] == bp[15]) && (t[15] != a[15]);
        r.sum_p1  = t1[15:0];
        r.cout_p1 = t1[16];
        r.ovf_p1  = (a[15] == bp[15]) && (t1[15] != a[15]);
        return r;
    endfunction

    task automatic drive(input rec_t r);
        bus.a   = r.a;
        bus.b   = r.b;
        bus.cin = r.cin;
        bus.op  = r.op;
    endtask

    task automatic chk_res(input string tag, input rec_t e);
        chk({tag, ".sum"},     64'(bus.sum),     64'(e.sum));
        chk({tag, ".cout"},    64'(bus.cout),    64'(e.cout));
        chk({tag, ".ovf"},     64'(bus.ovf),     64'(e.ovf));
        chk({tag, ".sum_p1"},  64'(bus.sum_p1),  64'(e.sum_p1));
        chk({tag, ".cout_p1"}, 64'(bus.cout_p1), 64'(e.cout_p1));
        chk({tag, ".ovf_p1"},  64'(bus.ovf_p1),  64'(e.ovf_p1));
    endtask

    rec_t vec [12];
    rec_t bpq [6];
    rec_t q [$];
    rec_t cur;
    rec_t e;

    initial begin
        int acc;
        int emit;
        int gaps;
        int lat;
        int nin;
        int nout;
        logic pending;
        logic [15:0] held_sum;
        logic [15:0] held_p1;

        //         a        b        cin   op    sum      co    ov    sum_p1   cp1   ovp1
        vec[0]  = mk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0);
        vec[1]  = mk(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        vec[2]  = mk(16'h7FFF, 16'h0000, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        vec[3]  = mk(16'hFFFE, 16'h0001, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        vec[4]  = mk(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 16'h0101, 1'b0, 1'b0);
        vec[5]  = mk(16'h00FE, 16'h0000, 1'b1, 1'b0, 16'h00FF, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        vec[6]  = mk(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
        vec[7]  = mk(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b0);
        vec[8]  = mk(16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 16'h8001, 1'b0, 1'b1);
        vec[9]  = mk(16'h0000, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        vec[10] = mk(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 16'h2346, 1'b0, 1'b0);
        vec[11] = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0);

        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drive(vec[11]);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst.in_ready",  64'(bus.in_ready),  64'd1);
        chk_res("rst", mk(16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0));

        // Directed vectors, one at a time, checking the two-cycle latency
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vec[i]);
            bus.in_valid = 1'b1;
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1;
            chk($sformatf("vec%0d.early_valid", i), 64'(bus.out_valid), 64'd0);
            @(negedge clk);
            #1;
            chk($sformatf("vec%0d.out_valid", i), 64'(bus.out_valid), 64'd1);
            chk_res($sformatf("vec%0d", i), vec[i]);
        end

        // Backpressure: six beats back-to-back, consumer stalls in cycles 3..7
        for (int j = 0; j < 6; j++)
            bpq[j] = model(16'h7FF0 + 16'(j * 8), 16'h0009 + 16'(j), 1'b0, 1'b0);
        acc = 0; emit = 0; gaps = 0; held_sum = '0; held_p1 = '0;
        for (int cyc = 0; cyc < 40 && emit < 6; cyc++) begin
            @(negedge clk);
            bus.out_ready = !(cyc >= 3 && cyc <= 7);
            if (acc < 6) begin
                drive(bpq[acc]);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (cyc >= 3 && cyc <= 7) begin
                chk($sformatf("bp.in_ready_c%0d", cyc), 64'(bus.in_ready), 64'd0);
                chk($sformatf("bp.valid_c%0d", cyc), 64'(bus.out_valid), 64'd1);
                if (cyc > 3) begin
                    chk($sformatf("bp.hold_sum_c%0d", cyc), 64'(bus.sum), 64'(held_sum));
                    chk($sformatf("bp.hold_p1_c%0d", cyc), 64'(bus.sum_p1), 64'(held_p1));
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                chk_res($sformatf("bp%0d", emit), bpq[emit]);
                emit++;
            end else if (emit > 0 && bus.out_ready) begin
                gaps++;
            end
            if (bus.in_valid && bus.in_ready) acc++;
            held_sum = bus.sum;
            held_p1  = bus.sum_p1;
        end
        chk("bp.count", 64'(emit), 64'd6);
        chk("bp.gaps",  64'(gaps), 64'd0);

        // Reset mid-flight: two beats in, consumer idle, one reset cycle
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(vec[0]);
        bus.in_valid = 1'b1;
        @(negedge clk);
        drive(vec[2]);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mrst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("mrst.in_ready",  64'(bus.in_ready),  64'd1);
        chk_res("mrst", mk(16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0));
        @(negedge clk);
        #1;
        chk("mrst.drained", 64'(bus.out_valid), 64'd0);
        drive(vec[7]);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        lat = 0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1;
            if (bus.out_valid) lat = k;
        end
        chk("mrst.latency", 64'(lat), 64'(S));
        chk_res("mrst.beat", vec[7]);

        // Random operands with random flow control against the reference model
        nin = 0; nout = 0; pending = 1'b0;
        for (int cyc = 0; cyc < 3000 && nout < 200; cyc++) begin
            @(negedge clk);
            bus.out_ready = 1'($urandom_range(0, 1));
            if (!pending && nin < 200 && $urandom_range(0, 3) != 0) begin
                cur = model(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
                drive(cur);
                pending = 1'b1;
            end
            bus.in_valid = pending;
            #1;
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd.underflow", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk_res($sformatf("rnd%0d", nout), e);
                end
                nout++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(cur);
                nin++;
                pending = 1'b0;
            end
        end
        chk("rnd.beats_in",  64'(nin),  64'd200);
        chk("rnd.beats_out", 64'(nout), 64'(nin));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
